// File: rtl/pci_initiator_burst_ctrl.sv
// PCI initiator burst sequencer: address phase, N data phases, STOP / DEVSEL-timeout termination.
// Optional PAR/PAR_oe generation is enabled by defining PCI_PARITY_GEN_EN.
module pci_initiator_burst_ctrl #(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DEVSEL_TMO = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [3:0]       req_cmd,
  input  logic [31:0]      req_addr,
  input  logic [3:0]       req_be,
  input  logic [CNT_W-1:0] req_len,
  input  logic [31:0]      wr_data,
  output logic             wr_ack,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       status,
  output logic             FRAME,
  output logic             IRDY,
  output logic [31:0]      AD_out,
  output logic             AD_oe,
  output logic [3:0]       CBE,
  input  logic [31:0]      AD_in,
  input  logic             TRDY,
  input  logic             DEVSEL,
  input  logic             STOP
`ifdef PCI_PARITY_GEN_EN
  ,
  output logic             PAR,
  output logic             PAR_oe
`endif
);

  localparam int unsigned TmoW = $clog2(DEVSEL_TMO + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(DEVSEL_TMO - 1);
  localparam logic [1:0] StatOk    = 2'd0;
  localparam logic [1:0] StatDisc  = 2'd1;
  localparam logic [1:0] StatAbort = 2'd2;

  typedef enum logic [2:0] {StIdle, StAddr, StData, StLast, StEnd} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d, rem_dec;
  logic [3:0]        cmd_q, cmd_d, be_q, be_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              seen_q, seen_d;
  logic [1:0]        status_q, status_d;
  logic [31:0]       ad_q, ad_d, rd_data_q;
  logic              frame_q, irdy_q, ad_oe_q, busy_q, done_q, wr_ack_q, rd_valid_q;
  logic [3:0]        cbe_q, cbe_d;
  logic              frame_d, irdy_d, ad_oe_d, hs, in_data_d;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    cmd_d    = cmd_q;
    be_d     = be_q;
    tmo_d    = tmo_q;
    seen_d   = seen_q;
    status_d = status_q;
    hs       = !irdy_q && !TRDY && (state_q == StData || state_q == StLast);
    rem_dec  = (rem_q == '0) ? '0 : rem_q - CNT_W'(1);

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d  = StAddr;
          cmd_d    = req_cmd;
          be_d     = req_be;
          rem_d    = (req_len == '0) ? CNT_W'(1) : req_len;
          tmo_d    = '0;
          seen_d   = 1'b0;
          status_d = StatOk;
        end
      end
      StAddr: state_d = StData;
      StData: begin
        if (hs) rem_d = rem_dec;
        if (!DEVSEL) seen_d = 1'b1;
        else if (!seen_q && tmo_q < TmoLast) tmo_d = tmo_q + TmoW'(1);
        if (!STOP) begin
          state_d  = frame_q ? StEnd : StLast;
          status_d = (rem_d != '0) ? StatDisc : StatOk;
        end else if (hs && rem_q == CNT_W'(1)) begin
          state_d = StEnd;
        end else if (!hs && DEVSEL && !seen_q && tmo_q == TmoLast) begin
          // Nobody claimed the cycle within the window: master abort.
          state_d  = StLast;
          status_d = StatAbort;
        end
      end
      StLast: begin
        if (hs) rem_d = rem_dec;
        // An aborted cycle has no target to finish it, so it leaves after one clock.
        if (!STOP || !TRDY || status_q == StatAbort) state_d = StEnd;
      end
      StEnd:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are registered as a function of the next state.
    in_data_d = (state_d == StData || state_d == StLast);
    frame_d   = !(state_d == StAddr || (state_d == StData && rem_d != CNT_W'(1)));
    irdy_d    = !in_data_d;
    ad_oe_d   = (state_d == StAddr) || (in_data_d && cmd_d[0]);
    cbe_d     = (state_d == StAddr) ? cmd_d : (in_data_d ? be_d : 4'hF);
    ad_d      = (state_d == StAddr) ? req_addr : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rem_q      <= '0;
      cmd_q      <= '0;
      be_q       <= 4'hF;
      tmo_q      <= '0;
      seen_q     <= 1'b0;
      status_q   <= StatOk;
      ad_q       <= '0;
      rd_data_q  <= '0;
      frame_q    <= 1'b1;
      irdy_q     <= 1'b1;
      ad_oe_q    <= 1'b0;
      cbe_q      <= 4'hF;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      cmd_q      <= cmd_d;
      be_q       <= be_d;
      tmo_q      <= tmo_d;
      seen_q     <= seen_d;
      status_q   <= status_d;
      ad_q       <= ad_d;
      frame_q    <= frame_d;
      irdy_q     <= irdy_d;
      ad_oe_q    <= ad_oe_d;
      cbe_q      <= cbe_d;
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_d == StEnd);
      wr_ack_q   <= hs && cmd_q[0];
      rd_valid_q <= hs && !cmd_q[0];
      if (hs && !cmd_q[0]) rd_data_q <= AD_in;
    end
  end

  // Write data passes straight through so a new word shows up as soon as local logic swaps it.
  assign AD_out   = ((state_q == StData || state_q == StLast) && cmd_q[0]) ? wr_data : ad_q;
  assign FRAME    = frame_q;
  assign IRDY     = irdy_q;
  assign AD_oe    = ad_oe_q;
  assign CBE      = cbe_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign status   = status_q;
  assign wr_ack   = wr_ack_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

`ifdef PCI_PARITY_GEN_EN
  logic par_q, par_oe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q    <= 1'b0;
      par_oe_q <= 1'b0;
    end else begin
      par_q    <= ad_oe_q ? (^AD_out ^ ^cbe_q) : 1'b0;
      par_oe_q <= ad_oe_q;
    end
  end

  assign PAR    = par_q;
  assign PAR_oe = par_oe_q;
`endif

endmodule

// File: tb/tb_pci_initiator_burst_ctrl.sv
// Randomized self-checking bench: a behavioural PCI target drives responses and a
// per-transaction outcome model predicts acks, read data, status and phase timing.
module tb_pci_initiator_burst_ctrl;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DEVSEL_TMO = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic [3:0]       req_cmd = '0;
  logic [31:0]      req_addr = '0;
  logic [3:0]       req_be = '0;
  logic [CNT_W-1:0] req_len = '0;
  logic [31:0]      wr_data = '0;
  logic             wr_ack, rd_valid, busy, done;
  logic [31:0]      rd_data, AD_out;
  logic [1:0]       status;
  logic             FRAME, IRDY, AD_oe;
  logic [3:0]       CBE;
  logic [31:0]      AD_in = '0;
  logic             TRDY = 1'b1, DEVSEL = 1'b1, STOP = 1'b1;
`ifdef PCI_PARITY_GEN_EN
  logic             PAR, PAR_oe;
`endif

  pci_initiator_burst_ctrl #(.CNT_W(CNT_W), .DEVSEL_TMO(DEVSEL_TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_be(req_be), .req_len(req_len), .wr_data(wr_data), .wr_ack(wr_ack), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy), .done(done), .status(status), .FRAME(FRAME), .IRDY(IRDY),
    .AD_out(AD_out), .AD_oe(AD_oe), .CBE(CBE), .AD_in(AD_in), .TRDY(TRDY), .DEVSEL(DEVSEL),
    .STOP(STOP)
`ifdef PCI_PARITY_GEN_EN
    , .PAR(PAR), .PAR_oe(PAR_oe)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] wrw [16];
  logic [31:0] rdw [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // stop_mode: 0 none, 1 STOP with TRDY on phase stop_at, 2 STOP without TRDY on phase stop_at
  task automatic run_txn(input logic [3:0] cmd, input logic [31:0] addr, input int len,
                         input int waits, input int stop_mode, input int stop_at,
                         input bit dev_on, input bit fixed_rd,
                         output int cycles, output int frame_hi_data);
    bit   wr = cmd[0];
    int   len_eff = (len == 0) ? 1 : len;
    int   exp_ph, exp_st;
    int   p = 0, wcnt = 0, need, n_wr = 0, n_rd = 0, n_done = 0, n_fa = 0;
    int   irdy_lo = 0, data_fr0 = 0, cbe_bad = 0;
    bit   stopped = 0, drove = 0, fin = 0;
    logic [3:0] be = 4'($urandom);

    if (!dev_on) begin exp_ph = 0; exp_st = 2; end
    else if (stop_mode == 1) begin exp_ph = stop_at; exp_st = (stop_at < len_eff) ? 1 : 0; end
    else if (stop_mode == 2) begin exp_ph = stop_at - 1; exp_st = 1; end
    else begin exp_ph = len_eff; exp_st = 0; end

    for (int i = 0; i < 16; i++) begin
      wrw[i] = $urandom;
      if (!fixed_rd) rdw[i] = $urandom;
    end
    cycles = 0;
    frame_hi_data = 0;

    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_be = be; req_len = CNT_W'(len);
    wr_data = wrw[0];
    for (int c = 0; c < 400 && !fin; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      cycles++;
      if (drove) begin p++; wcnt = 0; end
      drove = 0;
      wr_data = wrw[p % 16];
      #1;
      if (c == 0) begin
        check("addr_frame", 32'(FRAME), 32'd0);
        check("addr_ad", AD_out, addr);
        check("addr_cbe", 32'(CBE), 32'(cmd));
        check("addr_oe", 32'(AD_oe), 32'd1);
      end
`ifdef PCI_PARITY_GEN_EN
      if (c == 1) begin
        check("par", 32'(PAR), 32'(^addr ^ ^cmd));
        check("par_oe", 32'(PAR_oe), 32'd1);
      end
`endif
      if (wr_ack) n_wr++;
      if (rd_valid) begin
        check("rd_data", rd_data, rdw[n_rd % 16]);
        n_rd++;
      end
      if (!FRAME && IRDY) n_fa++;
      if (!IRDY) begin
        irdy_lo++;
        if (CBE !== be) cbe_bad++;
        if (FRAME) frame_hi_data++;
        else data_fr0++;
      end
      if (done) begin
        n_done++;
        check("status_at_done", 32'(status), 32'(exp_st));
      end
      if (!busy) fin = 1;

      // Target behaviour for the coming edge
      TRDY = 1'b1; STOP = 1'b1; DEVSEL = 1'b1; AD_in = '0;
      if (!IRDY && !fin) begin
        if (dev_on) DEVSEL = 1'b0;
        if (stopped) STOP = 1'b0;
        else if (dev_on) begin
          need = waits + ((!wr && p == 0) ? 1 : 0);
          if (wcnt < need) wcnt++;
          else if (stop_mode == 2 && p == stop_at - 1) begin
            STOP = 1'b0; stopped = 1;
          end else begin
            TRDY = 1'b0; drove = 1; AD_in = rdw[p % 16];
            if (wr) check("wr_word", AD_out, wrw[p % 16]);
            if (stop_mode == 1 && p == stop_at - 1) begin STOP = 1'b0; stopped = 1; end
          end
        end
      end
    end
    TRDY = 1'b1; STOP = 1'b1; DEVSEL = 1'b1;

    if (!fin) check("txn_bound", 32'd0, 32'd1);
    check("done_count", 32'(n_done), 32'd1);
    check("wr_ack_count", 32'(n_wr), wr ? 32'(exp_ph) : 32'd0);
    check("rd_valid_count", 32'(n_rd), wr ? 32'd0 : 32'(exp_ph));
    check("frame_before_irdy", 32'(n_fa), 32'd1);
    check("status_held", 32'(status), 32'(exp_st));
    check("cbe_data", 32'(cbe_bad), 32'd0);
    if (!dev_on && len_eff >= 2) check("tmo_data_clks", 32'(data_fr0), 32'(DEVSEL_TMO));
    if (dev_on && stop_mode == 0)
      check("irdy_low_clks", 32'(irdy_lo), 32'(len_eff * (waits + 1) + (wr ? 0 : 1)));
  endtask

  int cyc, fhd, len, waits, mode, k, le;
  bit wr, dev;

  initial begin
    #12;
    check("rst_frame", 32'(FRAME), 32'd1);
    check("rst_irdy", 32'(IRDY), 32'd1);
    check("rst_oe", 32'(AD_oe), 32'd0);
    check("rst_cbe", 32'(CBE), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_status", 32'(status), 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;

    // Zero-wait write burst of 4; address/command also exercise parity
    run_txn(4'h7, 32'h0000_0001, 4, 0, 0, 0, 1, 0, cyc, fhd);
    check("w4_cycles", 32'(cyc), 32'd7);
    check("w4_last_frame", 32'(fhd), 32'd1);

    // Read of 2 with two wait states per phase
    rdw[0] = 32'hA5A5_0001;
    rdw[1] = 32'hA5A5_0002;
    run_txn(4'h6, 32'h1000_0040, 2, 2, 0, 0, 1, 1, cyc, fhd);

    // Disconnect with data on phase 3 of 8
    run_txn(4'h7, 32'h2000_0000, 8, 0, 1, 3, 1, 0, cyc, fhd);
    check("disc_last", 32'(fhd), 32'd1);

    // No DEVSEL: master abort
    run_txn(4'h7, 32'h3000_0000, 4, 0, 0, 0, 0, 0, cyc, fhd);

    // Reset in the middle of a write data phase
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 4'h7; req_addr = 32'h4000_0000; req_len = 4'd4;
    @(negedge clk);
    req_valid = 1'b0;
    DEVSEL = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_frame", 32'(FRAME), 32'd1);
    check("mid_rst_irdy", 32'(IRDY), 32'd1);
    check("mid_rst_oe", 32'(AD_oe), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("mid_rst_done", 32'(done), 32'd0);
    DEVSEL = 1'b1;
    rst_n = 1'b1;
    run_txn(4'h7, 32'h4000_0100, 4, 0, 0, 0, 1, 0, cyc, fhd);
    check("post_rst_cycles", 32'(cyc), 32'd7);

    for (int t = 0; t < 40; t++) begin
      wr    = 1'($urandom_range(0, 1));
      len   = $urandom_range(0, 15);
      le    = (len == 0) ? 1 : len;
      waits = $urandom_range(0, 2);
      dev   = ($urandom_range(0, 9) != 0);
      mode  = dev ? $urandom_range(0, 2) : 0;
      k     = $urandom_range(1, le);
      run_txn({3'($urandom_range(0, 7)), wr}, $urandom, len, waits, mode, k, dev, 0, cyc, fhd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
